// File: rtl/memory_stage.sv
// memory_stage: Y86-64 PIPE memory stage (E->M register, data memory, status, sticky halt)
// Ports: clk/rst (sync, active-high); e_*/E_* inputs from Execute; M_stall/M_bubble control;
// M_* registered outputs; m_Value_M read data; m_stat final status; m_halted halt flag.
// Optional: define MEM_ALIGN_CHECK_EN to reject addresses with nonzero low three bits.
module memory_stage #(
  parameter int MEM_BYTES = 8192,
  parameter int ADDR_W    = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  e_Ins_Code,
  input  logic        e_Cnd,
  input  logic [63:0] e_Value_E,
  input  logic [63:0] E_value_A,
  input  logic [3:0]  e_dstE,
  input  logic [3:0]  E_dstM,
  input  logic [2:0]  E_stat,
  input  logic        M_stall,
  input  logic        M_bubble,
  output logic [3:0]  M_Ins_Code,
  output logic        M_Cnd,
  output logic [63:0] M_Value_E,
  output logic [63:0] M_value_A,
  output logic [3:0]  M_dstE,
  output logic [3:0]  M_dstM,
  output logic [63:0] m_Value_M,
  output logic [2:0]  m_stat,
  output logic        m_halted
);
  localparam int WORDS = MEM_BYTES / 8;
  localparam int IDX_W = $clog2(WORDS);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(MEM_BYTES - 8);
  typedef enum logic {RUN, HALTED} state_t;
  state_t r_state, w_next;
  logic [3:0]  r_icode, r_dste, r_dstm;
  logic        r_cnd;
  logic [63:0] r_vale, r_vala;
  logic [2:0]  r_stat;
  logic [63:0] r_mem [0:WORDS-1];
  logic [ADDR_W-1:0] w_addr;
  logic [IDX_W-1:0]  w_idx;
  logic w_rd, w_wr, w_valid, w_we;
  always_ff @(posedge clk) begin
    if (rst || M_bubble) begin
      r_icode <= 4'd1;
      r_cnd   <= 1'b0;
      r_vale  <= '0;
      r_vala  <= '0;
      r_dste  <= 4'hf;
      r_dstm  <= 4'hf;
      r_stat  <= 3'd0;
    end else if (!M_stall) begin
      r_icode <= e_Ins_Code;
      r_cnd   <= e_Cnd;
      r_vale  <= e_Value_E;
      r_vala  <= E_value_A;
      r_dste  <= e_dstE;
      r_dstm  <= E_dstM;
      r_stat  <= E_stat;
    end
  end
  always_comb begin
    w_rd   = r_icode inside {4'd5, 4'd9, 4'd11};
    w_wr   = r_icode inside {4'd4, 4'd8, 4'd10};
    w_addr = (r_icode inside {4'd9, 4'd11}) ? ADDR_W'(r_vala) : ADDR_W'(r_vale);
    // addr <= MEM_BYTES-8 is the overflow-free form of addr + 8 <= MEM_BYTES
`ifdef MEM_ALIGN_CHECK_EN
    w_valid = (w_addr <= LAST) && (w_addr[2:0] == 3'd0);
`else
    w_valid = w_addr <= LAST;
`endif
    w_idx     = w_addr[IDX_W+2:3];
    m_stat    = (r_stat != 3'd0) ? r_stat : ((w_rd || w_wr) && !w_valid) ? 3'd2 : 3'd0;
    m_Value_M = (w_rd && w_valid && r_stat == 3'd0) ? r_mem[w_idx] : 64'd0;
    w_we      = w_wr && w_valid && r_stat == 3'd0 && r_state == RUN && !M_stall && !rst;
    w_next    = (r_state == RUN && !M_stall && m_stat != 3'd0) ? HALTED : r_state;
  end
  always_ff @(posedge clk) r_state <= rst ? RUN : w_next;
  always_ff @(posedge clk) if (w_we) r_mem[w_idx] <= r_vala;
  assign M_Ins_Code = r_icode;
  assign M_Cnd      = r_cnd;
  assign M_Value_E  = r_vale;
  assign M_value_A  = r_vala;
  assign M_dstE     = r_dste;
  assign M_dstM     = r_dstm;
  assign m_halted   = r_state == HALTED;
endmodule

// File: tb/tb_memory_stage.sv
// tb_memory_stage: scoreboard bench for memory_stage with directed vectors
module tb_memory_stage;
  localparam int MB = 8192;
  logic clk = 0, rst = 1;
  logic [3:0] e_Ins_Code, e_dstE, E_dstM, M_Ins_Code, M_dstE, M_dstM;
  logic e_Cnd, M_stall, M_bubble, M_Cnd, m_halted;
  logic [63:0] e_Value_E, E_value_A, M_Value_E, M_value_A, m_Value_M;
  logic [2:0] E_stat, m_stat;
  int n_vec = 0, n_err = 0;
  string q_name[$];
  int q_sel[$];
  logic [63:0] q_exp[$];
  memory_stage #(.MEM_BYTES(MB), .ADDR_W(64)) dut (
    .clk(clk), .rst(rst), .e_Ins_Code(e_Ins_Code), .e_Cnd(e_Cnd), .e_Value_E(e_Value_E),
    .E_value_A(E_value_A), .e_dstE(e_dstE), .E_dstM(E_dstM), .E_stat(E_stat),
    .M_stall(M_stall), .M_bubble(M_bubble), .M_Ins_Code(M_Ins_Code), .M_Cnd(M_Cnd),
    .M_Value_E(M_Value_E), .M_value_A(M_value_A), .M_dstE(M_dstE), .M_dstM(M_dstM),
    .m_Value_M(m_Value_M), .m_stat(m_stat), .m_halted(m_halted));
  always #5 clk = ~clk;
  function automatic logic [63:0] actual(int sel);
    case (sel)
      0: return 64'(M_Ins_Code);
      1: return 64'(M_Cnd);
      2: return M_Value_E;
      3: return M_value_A;
      4: return 64'(M_dstE);
      5: return 64'(M_dstM);
      6: return m_Value_M;
      7: return 64'(m_stat);
      default: return 64'(m_halted);
    endcase
  endfunction
  always @(negedge clk) begin
    while (q_sel.size() > 0) begin
      string nm;
      int s;
      logic [63:0] e, a;
      nm = q_name.pop_front();
      s = q_sel.pop_front();
      e = q_exp.pop_front();
      a = actual(s);
      n_vec++;
      if (a !== e) begin
        n_err++;
        $display("FAIL %s: got 0x%0h expected 0x%0h", nm, a, e);
      end
    end
  end
  task automatic expect_v(string nm, int sel, logic [63:0] v);
    q_name.push_back(nm);
    q_sel.push_back(sel);
    q_exp.push_back(v);
  endtask
  task automatic drive(logic [3:0] ic, logic [63:0] ve, logic [63:0] va,
                       logic [2:0] st = 3'd0, logic [3:0] de = 4'hf, logic cnd = 1'b0);
    e_Ins_Code = ic; e_Value_E = ve; E_value_A = va; E_stat = st;
    e_dstE = de; E_dstM = 4'hf; e_Cnd = cnd;
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    M_stall = 0; M_bubble = 0;
    drive(4'd1, 0, 0);
    tick(); tick();
    rst = 0;
    expect_v("rst_icode", 0, 1);
    expect_v("rst_dstE", 4, 15);
    expect_v("rst_dstM", 5, 15);
    expect_v("rst_mstat", 7, 0);
    expect_v("rst_halted", 8, 0);
    expect_v("rst_valM", 6, 0);
    tick();
    expect_v("idle_icode", 0, 1);
    drive(4'd4, 64'h40, 64'hDEADBEEF);
    tick();
    drive(4'd5, 64'h40, 0, 3'd0, 4'hf, 1'b1);
    tick();
    expect_v("ld_valM", 6, 64'hDEADBEEF);
    expect_v("ld_mstat", 7, 0);
    expect_v("ld_valE", 2, 64'h40);
    expect_v("ld_cnd", 1, 1);
    drive(4'd10, 64'h100, 64'h55, 3'd0, 4'd4);
    tick();
    expect_v("push_dstE", 4, 4);
    M_stall = 1;
    drive(4'd11, 64'h108, 64'h100);
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_v("stall_icode", 0, 10);
      expect_v("stall_valA", 3, 64'h55);
      expect_v("stall_valE", 2, 64'h100);
    end
    M_stall = 0;
    tick();
    expect_v("pop_icode", 0, 11);
    expect_v("pop_valM", 6, 64'h55);
    drive(4'd4, 64'h80, 64'h77);
    tick();
    drive(4'd1, 0, 0);
    tick();
    drive(4'd4, 64'h80, 64'h22);
    M_bubble = 1; M_stall = 1;
    tick();
    expect_v("bub_icode", 0, 1);
    expect_v("bub_dstE", 4, 15);
    M_bubble = 0; M_stall = 0;
    drive(4'd5, 64'h80, 0);
    tick();
    expect_v("bub_nowrite", 6, 64'h77);
    drive(4'd5, 64'(MB - 4), 0);
    tick();
    expect_v("oob_mstat", 7, 2);
    expect_v("oob_valM", 6, 0);
    expect_v("oob_prehalt", 8, 0);
    drive(4'd4, 64'h80, 64'h11);
    tick();
    expect_v("oob_halted", 8, 1);
    drive(4'd1, 0, 0);
    tick();
    expect_v("halt_sticky", 8, 1);
    rst = 1;
    tick();
    rst = 0;
    drive(4'd5, 64'h80, 0);
    tick();
    expect_v("halt_nowrite", 6, 64'h77);
    expect_v("rst_unhalt", 8, 0);
    drive(4'd0, 0, 0, 3'd1);
    tick();
    expect_v("hlt_mstat", 7, 1);
    expect_v("hlt_icode", 0, 0);
    drive(4'd1, 0, 0);
    tick();
    expect_v("hlt_halted", 8, 1);
    drive(4'd5, 64'h43, 0);
    tick();
`ifdef MEM_ALIGN_CHECK_EN
    expect_v("align_mstat", 7, 2);
    expect_v("align_valM", 6, 0);
`else
    expect_v("unalign_mstat", 7, 0);
    expect_v("unalign_valM", 6, 64'hDEADBEEF);
`endif
    @(negedge clk);
    #1;
    if (q_sel.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", q_sel.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
